// File: rtl/param_seq_detector_if.sv
// param_seq_detector_if: serial input and detector status bundle; carries match_now when SEQ_DET_MEALY_EN is defined.
interface param_seq_detector_if #(
  parameter int PW = 3,
  parameter int CNT_W = 4
);
  logic x;
  logic en;
  logic match;
  logic sat;
  logic [PW-1:0] progress;
  logic [CNT_W-1:0] count;
`ifdef SEQ_DET_MEALY_EN
  logic match_now;
  modport master (output x, en, input match, progress, count, sat, match_now);
  modport slave (input x, en, output match, progress, count, sat, match_now);
`else
  modport master (output x, en, input match, progress, count, sat);
  modport slave (input x, en, output match, progress, count, sat);
`endif
endinterface

// File: rtl/param_seq_detector.sv
// param_seq_detector: KMP-style serial pattern detector with registered match, saturating count,
// and an optional combinational match_now output enabled by SEQ_DET_MEALY_EN.
module param_seq_detector #(
  parameter int LEN = 4,
  parameter logic [LEN-1:0] PATTERN = 4'b1101,
  parameter int OVERLAP = 1,
  parameter int CNT_W = 4,
  parameter int PW = $clog2(LEN + 1)
) (
  input logic clk,
  input logic reset,
  param_seq_detector_if.slave bus
);
  // Longest proper pattern prefix that ends the string (matched prefix of length s, then bit b).
  function automatic int fallback(int s, int b);
    int r;
    int i;
    logic ok;
    logic t;
    r = 0;
    for (int k = 1; k <= s + 1 && k < LEN; k++) begin
      ok = 1'b1;
      for (int j = 0; j < k; j++) begin
        i = s + 1 - k + j;
        t = (i == s) ? b[0] : PATTERN[LEN-1-i];
        ok = ok & (t == PATTERN[LEN-1-j]);
      end
      r = ok ? k : r;
    end
    return r;
  endfunction
  logic [PW-1:0] nxt [LEN][2];
  for (genvar s = 0; s < LEN; s++) begin : g_s
    for (genvar b = 0; b < 2; b++) begin : g_b
      localparam int F = fallback(s, b);
      assign nxt[s][b] = PW'(F);
    end
  end
  logic [PW-1:0] s, s_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic match_q, sat_q, hit;
  always_comb begin
    hit = bus.en & (s == PW'(LEN - 1)) & (bus.x == PATTERN[0]);
    s_nxt = s;
    for (int i = 0; i < LEN; i++)
      s_nxt = (bus.en && s == PW'(i)) ? nxt[i][bus.x] : s_nxt;
    s_nxt = (hit && OVERLAP == 0) ? '0 : s_nxt;
    cnt_nxt = (hit && !(&cnt)) ? cnt + CNT_W'(1) : cnt;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      s <= '0;
      match_q <= 1'b0;
      cnt <= '0;
      sat_q <= 1'b0;
    end else begin
      s <= s_nxt;
      match_q <= hit;
      cnt <= cnt_nxt;
      sat_q <= &cnt_nxt;
    end
  end
  assign bus.progress = s;
  assign bus.match = match_q;
  assign bus.count = cnt;
  assign bus.sat = sat_q;
`ifdef SEQ_DET_MEALY_EN
  assign bus.match_now = hit & ~reset;
`endif
endmodule

// File: doc/param_seq_detector.md
Name: param_seq_detector

Overview:
- Parametrised serial-bit sequence detector, built as a Moore FSM, with an optional Mealy output.
- Samples a 1-bit input `x` on each enabled clock and recognises a compile-time `PATTERN` of `LEN` bits, MSB received first.
- Supports overlapping and non-overlapping matching, and counts matches with a saturating counter.
- Replaces the fixed-pattern, single-mode sequence FSMs used in the lab designs.

Parameters:
- LEN, 4, pattern length in bits (2..16).
- PATTERN, 4'b1101, target sequence; `PATTERN[LEN-1]` is the first bit expected.
- OVERLAP, 1, 1 = overlapping matches allowed, 0 = restart from empty after a match.
- CNT_W, 4, match counter width.
- PW, $clog2(LEN+1), progress output width (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- x  input  1  serial data bit, sampled on clk rising edge when en=1.
- en  input  1  sample enable.
- match  output  1  registered one-cycle pulse on pattern completion.
- progress  output  PW  current FSM state = number of pattern prefix bits currently matched (0..LEN-1).
- count  output  CNT_W  number of matches, saturating.
- sat  output  1  high while count == 2^CNT_W-1.

Behaviour:
- **Clock and reset:** one clock, clk. Reset is synchronous and active-high (reset). All state updates occur on the rising edge of clk.
- **Reset values:** progress=0, match=0, count=0, sat=0. Reset has priority over en. Reset mid-pattern discards partial progress.
- **State:** s in 0..LEN-1 = length of the longest pattern prefix that is a suffix of the bits sampled so far. progress = s.
- **Transition on en=1, normal advance:** let b = PATTERN[LEN-1-s]. If x==b and s<LEN-1, then s_next = s+1.
- **Transition on en=1, mismatch:** s_next = length of the longest proper prefix of PATTERN that is a suffix of (matched prefix followed by x). This is the KMP fallback, computed from PATTERN at elaboration time or by a combinational search; no runtime table is loaded.
- **Completion (s==LEN-1 and x==PATTERN[0]):**
  - match=1 for exactly one cycle, registered, so visible after the same edge.
  - If OVERLAP=1, s_next = failure(LEN), the longest proper prefix that is also a suffix of PATTERN.
  - If OVERLAP=0, s_next = 0.
- **en=0:** s, count and sat hold; match is driven 0; x is ignored.
- **count:** increments by 1 on each completion edge. It holds at 2^CNT_W-1 and never wraps. sat is registered alongside count.
- **Back-to-back matches** (OVERLAP=1, short failure distance) produce match high on consecutive enabled cycles where the pattern permits.
- **Degenerate patterns** (e.g. all ones): with OVERLAP=1 the detector matches on every enabled cycle once LEN bits are accumulated.

Optional Feature:
- Macro: SEQ_DET_MEALY_EN.
- **When defined:**
  - Adds output `match_now` (1 bit), combinational: match_now = en & ~reset & (s==LEN-1) & (x==PATTERN[0]).
  - match_now leads `match` by one cycle, asserting in the cycle the final bit is present.
- **When undefined:** the port and its logic are absent; all other behaviour is identical.

Test Plan:
- **Reset hold:** reset=1 for 3 cycles while x toggles 1,0,1 with en=1 -> progress=0, match=0, count=0, sat=0 throughout.
- **Single match:** PATTERN=1101, OVERLAP=1, en=1, x=1,1,0,1 -> progress 1,2,3 after edges 1..3; match=1 for one cycle after edge 4; count=1; progress=1 afterwards.
- **Overlap mode:** x=1,1,0,1,1,0,1 -> OVERLAP=1 gives two match pulses (edges 4 and 7), count=2. OVERLAP=0 gives one pulse (edge 4), count=1, progress=1 at end.
- **Fallback:** x=1,1,1,0,1 -> progress 1,2,2,3 then match at edge 5. Separately, from progress=3, x=0 -> progress=0.
- **Enable gating:** feed 1,1 then en=0 for 3 cycles with x=0,0,0 -> progress stays 2, match 0. Re-enable and feed 0,1 -> match pulse, count increments.
- **Saturation and reset:** CNT_W=2, feed 5 non-adjacent matches -> count 1,2,3,3,3; sat=1 from the 3rd match. Then reset at progress=2 -> all outputs 0, and the next match requires the full 4-bit pattern. With SEQ_DET_MEALY_EN, match_now is high one cycle before each match pulse.
